param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of entries; it SHALL be a power of two and at least 2.
REQ-004 Parameter AF_LEVEL, default DEPTH-2, SHALL set the almost_full threshold.
REQ-005 Parameter AE_LEVEL, default 2, SHALL set the almost_empty threshold.
REQ-006 Localparam AW SHALL equal log2(DEPTH).
REQ-007 Port clk, input, 1 bit: rising-edge clock.
REQ-008 Port rst, input, 1 bit: synchronous active-high reset.
REQ-009 Port flush, input, 1 bit: synchronous empty request.
REQ-010 Port wr_en, input, 1 bit: write request.
REQ-011 Port wr_data, input, DATA_WIDTH bits: write word.
REQ-012 Port rd_en, input, 1 bit: read request.
REQ-013 Port rd_data, output, DATA_WIDTH bits: registered read word.
REQ-014 Port rd_valid, output, 1 bit: rd_data holds a newly read word.
REQ-015 Ports full and empty, outputs, 1 bit each: occupancy equals DEPTH and 0 respectively.
REQ-016 Ports almost_full and almost_empty, outputs, 1 bit each: count >= AF_LEVEL and count <= AE_LEVEL respectively.
REQ-017 Port count, output, AW+1 bits: stored entries, 0..DEPTH.
REQ-018 Ports overflow and underflow, outputs, 1 bit each: one-cycle pulses for a rejected write and a rejected read respectively.

Function
REQ-019 A write SHALL be accepted iff wr_en=1 and full=0 at the clock edge; the word SHALL be stored at wr_ptr, and wr_ptr SHALL then increment modulo DEPTH.
REQ-020 A read SHALL be accepted iff rd_en=1 and empty=0; mem[rd_ptr] SHALL be registered onto rd_data, rd_valid SHALL be 1 the next cycle, and rd_ptr SHALL increment modulo DEPTH.
REQ-021 Read latency SHALL be exactly one cycle from the accepting edge; rd_valid SHALL be 0 in any cycle following an edge with no accepted read.
REQ-022 rd_data SHALL hold its last value when no read is accepted.
REQ-023 An accepted write and an accepted read on the same edge SHALL both complete, leaving count unchanged.
REQ-024 When full=1, simultaneous wr_en=1 and rd_en=1 SHALL accept the read only; the write SHALL be rejected and overflow SHALL pulse.
REQ-025 When empty=1, simultaneous wr_en=1 and rd_en=1 SHALL accept the write only; the read SHALL be rejected (no write-through) and underflow SHALL pulse.
REQ-026 count SHALL update as count + accepted_write - accepted_read; full, empty, almost_full and almost_empty SHALL be registered and consistent with the updated count in the same cycle.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss or reordering; ordering SHALL be strictly first-in first-out.
REQ-028 flush=1 SHALL zero wr_ptr, rd_ptr and count, set empty=1, and clear full, overflow and underflow; it SHALL take priority over wr_en and rd_en on the same edge, with both ignored.
REQ-029 On a flush edge rd_valid SHALL be 0 next cycle and rd_data SHALL hold; flush SHALL NOT pulse overflow or underflow.
REQ-030 Memory contents SHALL NOT be required to clear on flush or reset; unwritten entries SHALL never be readable.

Reset
REQ-031 While rst=1 at a clock edge: pointers=0, count=0, rd_data=0, rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-032 rst SHALL take priority over flush, wr_en and rd_en; a reset mid-operation SHALL discard all stored entries.

Verification
REQ-033 Defaults: write 0x01..0x10 on 16 consecutive edges -> full=1 and count=16 after the last edge; almost_full=1 from count=14.
REQ-034 Full FIFO, wr_en=1 with 0xAA -> overflow pulses one cycle, count stays 16, and 16 reads return 0x01..0x10 in order with rd_valid one cycle after each rd_en.
REQ-035 Empty FIFO, rd_en=1 -> underflow pulses, rd_valid=0, rd_data unchanged.
REQ-036 Hold count=5 with wr_en=rd_en=1 for 40 cycles -> count stays 5, pointers wrap twice, and output order matches input order.
REQ-037 Count=7 with flush=1 and wr_en=1 on the same edge -> count=0 and empty=1; a following read gives underflow.
REQ-038 Assert rst after 9 writes -> all outputs reach their REQ-031 values next cycle; the first write after reset is the first word read.

Source files
------------

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with registered read port, registered occupancy flags
// and one-cycle overflow/underflow pulses.
module param_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AfLvl    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AeLvl    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CntOne   = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;

  // Acceptance is decided from the registered flags, so a full FIFO never writes through
  // a simultaneous read and an empty FIFO never reads through a simultaneous write.
  always_comb begin
    wr_acc   = 1'b0;
    rd_acc   = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_acc = wr_en & ~full_q;
      rd_acc = rd_en & ~empty_q;
      ovf_d  = wr_en & full_q;
      udf_d  = rd_en & empty_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AfLvl);
    ae_d    = (count_d <= AeLvl);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      if (rd_acc) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Storage is never cleared; the pointers alone decide which entries are readable.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
